// File: rtl/wb_commit_unit.sv
// rtl/wb_commit_unit.sv - write-back/commit stage: regfile/CSR/trap strobes and next-PC handoff
module wb_commit_unit #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = 32'h3000_0000,
    parameter logic [XLEN-1:0] ECALL_CAUSE = 32'd11
) (
    input  logic            clock,
    input  logic            i_rst_n,
    input  logic            i_pre_valid,
    output logic            o_pre_ready,
    input  logic [XLEN-1:0] i_res,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_imm,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [4:0]      i_rd,
    input  logic            i_rd_wen,
    input  logic            i_brch,
    input  logic            i_jal,
    input  logic            i_jalr,
    input  logic            i_ecall,
    input  logic            i_mret,
    input  logic            i_csr_wen,
    input  logic [11:0]     i_csr_addr,
    input  logic [XLEN-1:0] i_csr_rdata,
    input  logic [XLEN-1:0] i_mtvec,
    input  logic [XLEN-1:0] i_mepc,
    output logic            o_rf_wen,
    output logic [4:0]      o_rf_waddr,
    output logic [XLEN-1:0] o_rf_wdata,
    output logic            o_csr_wen,
    output logic [11:0]     o_csr_waddr,
    output logic [XLEN-1:0] o_csr_wdata,
    output logic            o_trap_wen,
    output logic [XLEN-1:0] o_mepc,
    output logic [XLEN-1:0] o_mcause,
    output logic [XLEN-1:0] o_npc,
    output logic            o_npc_valid,
    input  logic            i_ifu_ready
);

    typedef enum logic [1:0] {S_IDLE, S_WB, S_NPC} state_t;

    state_t          r_state;
    logic            r_pre_ready;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_imm;
    logic [XLEN-1:0] r_rs1;
    logic            r_taken;
    logic            r_brch;
    logic            r_jal;
    logic            r_jalr;
    logic            r_ecall;
    logic            r_mret;
    logic [XLEN-1:0] r_mtvec;
    logic [XLEN-1:0] r_mepc_in;
    logic            r_rf_wen;
    logic [4:0]      r_rf_waddr;
    logic [XLEN-1:0] r_rf_wdata;
    logic            r_csr_wen;
    logic [11:0]     r_csr_waddr;
    logic [XLEN-1:0] r_csr_wdata;
    logic            r_trap_wen;
    logic [XLEN-1:0] r_mepc;
    logic [XLEN-1:0] r_npc;
    logic            r_npc_valid;

    logic [XLEN-1:0] w_pc_imm;
    logic [XLEN-1:0] w_rs1_imm;
    logic [XLEN-1:0] w_npc;

    // Next-PC selection from the captured instruction; ecall outranks every other redirect
    always_comb begin
        w_pc_imm  = r_pc + r_imm;
        w_rs1_imm = r_rs1 + r_imm;
        w_npc     = r_pc + XLEN'(4);
        if (r_ecall)               w_npc = r_mtvec;
        else if (r_mret)           w_npc = r_mepc_in;
        else if (r_jal)            w_npc = w_pc_imm;
        else if (r_jalr)           w_npc = {w_rs1_imm[XLEN-1:1], 1'b0};
        else if (r_brch && r_taken) w_npc = w_pc_imm;
    end

    // Commit FSM: capture at handshake, strobe for one WB cycle, hold next PC until fetch takes it
    always_ff @(posedge clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_pre_ready <= 1'b1;
            r_pc        <= '0;
            r_imm       <= '0;
            r_rs1       <= '0;
            r_taken     <= 1'b0;
            r_brch      <= 1'b0;
            r_jal       <= 1'b0;
            r_jalr      <= 1'b0;
            r_ecall     <= 1'b0;
            r_mret      <= 1'b0;
            r_mtvec     <= '0;
            r_mepc_in   <= '0;
            r_rf_wen    <= 1'b0;
            r_rf_waddr  <= '0;
            r_rf_wdata  <= '0;
            r_csr_wen   <= 1'b0;
            r_csr_waddr <= '0;
            r_csr_wdata <= '0;
            r_trap_wen  <= 1'b0;
            r_mepc      <= '0;
            r_npc       <= RESET_PC;
            r_npc_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_pre_valid && r_pre_ready) begin
                        r_pc        <= i_pc;
                        r_imm       <= i_imm;
                        r_rs1       <= i_rs1;
                        r_taken     <= i_res[0];
                        r_brch      <= i_brch;
                        r_jal       <= i_jal;
                        r_jalr      <= i_jalr;
                        r_ecall     <= i_ecall;
                        r_mret      <= i_mret;
                        r_mtvec     <= i_mtvec;
                        r_mepc_in   <= i_mepc;
                        // Strobes are registered here so they are high exactly during WB
                        r_rf_wen    <= i_rd_wen && (i_rd != 5'd0);
                        r_rf_waddr  <= i_rd;
                        r_rf_wdata  <= i_csr_wen ? i_csr_rdata : i_res;
                        r_csr_wen   <= i_csr_wen;
                        r_csr_waddr <= i_csr_addr;
                        r_csr_wdata <= i_res;
                        r_trap_wen  <= i_ecall;
                        r_mepc      <= i_pc;
                        r_pre_ready <= 1'b0;
                        r_state     <= S_WB;
                    end
                end
                S_WB: begin
                    r_rf_wen    <= 1'b0;
                    r_csr_wen   <= 1'b0;
                    r_trap_wen  <= 1'b0;
                    r_npc       <= w_npc;
                    r_npc_valid <= 1'b1;
                    r_state     <= S_NPC;
                end
                S_NPC: begin
                    if (i_ifu_ready) begin
                        r_npc_valid <= 1'b0;
                        r_pre_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_npc_valid <= 1'b0;
                    r_pre_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign o_pre_ready = r_pre_ready;
    assign o_rf_wen    = r_rf_wen;
    assign o_rf_waddr  = r_rf_waddr;
    assign o_rf_wdata  = r_rf_wdata;
    assign o_csr_wen   = r_csr_wen;
    assign o_csr_waddr = r_csr_waddr;
    assign o_csr_wdata = r_csr_wdata;
    assign o_trap_wen  = r_trap_wen;
    assign o_mepc      = r_mepc;
    assign o_mcause    = ECALL_CAUSE;
    assign o_npc       = r_npc;
    assign o_npc_valid = r_npc_valid;

endmodule

// File: tb/tb_wb_commit_unit.sv
// tb/tb_wb_commit_unit.sv - self-checking bench for wb_commit_unit
module tb_wb_commit_unit;

    localparam logic [31:0] RESET_PC = 32'h3000_0000;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        pre_valid = 1'b0;
    logic        pre_ready;
    logic [31:0] res = '0, pc = '0, imm = '0, rs1 = '0;
    logic [4:0]  rd = '0;
    logic        rd_wen = 1'b0, brch = 1'b0, jal = 1'b0, jalr = 1'b0, ecall = 1'b0, mret = 1'b0;
    logic        csr_wen_i = 1'b0;
    logic [11:0] csr_addr = '0;
    logic [31:0] csr_rdata = '0, mtvec = '0, mepc_i = '0;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        csr_wen;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        trap_wen;
    logic [31:0] mepc, mcause, npc;
    logic        npc_valid;
    logic        ifu_ready = 1'b0;

    int total = 0;
    int bad = 0;

    wb_commit_unit dut (
        .clock(clock), .i_rst_n(rst_n),
        .i_pre_valid(pre_valid), .o_pre_ready(pre_ready),
        .i_res(res), .i_pc(pc), .i_imm(imm), .i_rs1(rs1),
        .i_rd(rd), .i_rd_wen(rd_wen),
        .i_brch(brch), .i_jal(jal), .i_jalr(jalr), .i_ecall(ecall), .i_mret(mret),
        .i_csr_wen(csr_wen_i), .i_csr_addr(csr_addr), .i_csr_rdata(csr_rdata),
        .i_mtvec(mtvec), .i_mepc(mepc_i),
        .o_rf_wen(rf_wen), .o_rf_waddr(rf_waddr), .o_rf_wdata(rf_wdata),
        .o_csr_wen(csr_wen), .o_csr_waddr(csr_waddr), .o_csr_wdata(csr_wdata),
        .o_trap_wen(trap_wen), .o_mepc(mepc), .o_mcause(mcause),
        .o_npc(npc), .o_npc_valid(npc_valid), .i_ifu_ready(ifu_ready)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] res, pc, imm, rs1;
        logic [4:0]  rd;
        logic        rd_wen, brch, jal, jalr, ecall, mret, csr_wen;
        logic [11:0] csr_addr;
        logic [31:0] csr_rdata, mtvec, mepc;
    } in_t;

    typedef struct {
        logic        rf_wen;
        logic [31:0] rf_wdata;
        logic        csr_wen;
        logic        trap_wen;
        logic [31:0] npc;
    } exp_t;

    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    // ctrl = {brch, jal, jalr, ecall, mret}
    function automatic in_t mk(logic [31:0] p, logic [31:0] r, logic [31:0] im, logic [31:0] s1,
                               logic [4:0] d, logic dw, logic [4:0] ctrl, logic cw);
        in_t v;
        v.pc = p; v.res = r; v.imm = im; v.rs1 = s1; v.rd = d; v.rd_wen = dw;
        v.brch = ctrl[4]; v.jal = ctrl[3]; v.jalr = ctrl[2]; v.ecall = ctrl[1]; v.mret = ctrl[0];
        v.csr_wen = cw; v.csr_addr = 12'h305; v.csr_rdata = 32'h0000_ABCD;
        v.mtvec = 32'h800; v.mepc = 32'h404;
        return v;
    endfunction

    function automatic exp_t mke(logic w, logic [31:0] wd, logic cw, logic tw, logic [31:0] n);
        exp_t e;
        e.rf_wen = w; e.rf_wdata = wd; e.csr_wen = cw; e.trap_wen = tw; e.npc = n;
        return e;
    endfunction

    // Reference: commit rules stated directly as arithmetic on the instruction fields
    function automatic exp_t model(in_t v);
        exp_t e;
        logic [31:0] t;
        e.rf_wen   = v.rd_wen && (v.rd != 0);
        e.rf_wdata = v.csr_wen ? v.csr_rdata : v.res;
        e.csr_wen  = v.csr_wen;
        e.trap_wen = v.ecall;
        t = v.rs1 + v.imm;
        if (v.ecall)                   e.npc = v.mtvec;
        else if (v.mret)               e.npc = v.mepc;
        else if (v.jal)                e.npc = v.pc + v.imm;
        else if (v.jalr)               e.npc = t - {31'd0, t[0]};
        else if (v.brch && v.res[0])   e.npc = v.pc + v.imm;
        else                           e.npc = v.pc + 32'd4;
        return e;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(in_t v);
        res = v.res; pc = v.pc; imm = v.imm; rs1 = v.rs1; rd = v.rd; rd_wen = v.rd_wen;
        brch = v.brch; jal = v.jal; jalr = v.jalr; ecall = v.ecall; mret = v.mret;
        csr_wen_i = v.csr_wen; csr_addr = v.csr_addr; csr_rdata = v.csr_rdata;
        mtvec = v.mtvec; mepc_i = v.mepc;
    endtask

    task automatic scramble();
        res = $urandom; pc = $urandom; imm = $urandom; rs1 = $urandom; rd = 5'($urandom);
        rd_wen = 1'($urandom); brch = 1'($urandom); jal = 1'($urandom); jalr = 1'($urandom);
        ecall = 1'($urandom); mret = 1'($urandom); csr_wen_i = 1'($urandom);
        csr_addr = 12'($urandom); csr_rdata = $urandom; mtvec = $urandom; mepc_i = $urandom;
    endtask

    // One full instruction: accept, check WB strobes, check NPC (optionally stalled), release
    task automatic apply(string tag, in_t v, exp_t e, int stall);
        int n;
        n = 0;
        while (!pre_ready && n < 20) begin @(negedge clock); n++; end
        if (!pre_ready) begin
            check({tag, " wait_ready"}, {31'd0, pre_ready}, 32'd1);
            return;
        end
        drive(v);
        pre_valid = 1'b1;
        ifu_ready = (stall == 0);
        @(posedge clock);
        #1;
        scramble();              // pre_valid stays high: must be ignored outside IDLE
        @(negedge clock);
        check({tag, " rf_wen"},    {31'd0, rf_wen}, {31'd0, e.rf_wen});
        check({tag, " rf_waddr"},  {27'd0, rf_waddr}, {27'd0, v.rd});
        check({tag, " rf_wdata"},  rf_wdata, e.rf_wdata);
        check({tag, " csr_wen"},   {31'd0, csr_wen}, {31'd0, e.csr_wen});
        check({tag, " csr_waddr"}, {20'd0, csr_waddr}, {20'd0, v.csr_addr});
        check({tag, " csr_wdata"}, csr_wdata, v.res);
        check({tag, " trap_wen"},  {31'd0, trap_wen}, {31'd0, e.trap_wen});
        check({tag, " mepc"},      mepc, v.pc);
        check({tag, " mcause"},    mcause, 32'd11);
        check({tag, " wb_nvalid"}, {31'd0, npc_valid}, 32'd0);
        check({tag, " wb_ready"},  {31'd0, pre_ready}, 32'd0);
        @(negedge clock);
        check({tag, " npc_valid"}, {31'd0, npc_valid}, 32'd1);
        check({tag, " npc"},       npc, e.npc);
        check({tag, " npc_ready"}, {31'd0, pre_ready}, 32'd0);
        check({tag, " strobes_off"}, {29'd0, rf_wen, csr_wen, trap_wen}, 32'd0);
        for (int k = 1; k < stall; k++) begin
            @(negedge clock);
            check({tag, " hold_valid"}, {31'd0, npc_valid}, 32'd1);
            check({tag, " hold_npc"},   npc, e.npc);
            check({tag, " hold_ready"}, {31'd0, pre_ready}, 32'd0);
        end
        pre_valid = 1'b0;
        ifu_ready = 1'b1;
        @(negedge clock);
        check({tag, " back_ready"}, {31'd0, pre_ready}, 32'd1);
        check({tag, " back_nvalid"}, {31'd0, npc_valid}, 32'd0);
    endtask

    vec_t vecs[12];

    initial begin
        in_t r;
        int sel;

        vecs[0].i  = mk(32'h100, 32'd5, 32'd0, 32'd0, 5'd3, 1'b1, 5'b00000, 1'b0);
        vecs[0].e  = mke(1'b1, 32'd5, 1'b0, 1'b0, 32'h104);
        vecs[1].i  = mk(32'h10, 32'd7, 32'd0, 32'd0, 5'd0, 1'b1, 5'b00000, 1'b0);
        vecs[1].e  = mke(1'b0, 32'd7, 1'b0, 1'b0, 32'h14);
        vecs[2].i  = mk(32'h200, 32'd1, 32'hFFFF_FFF8, 32'd0, 5'd0, 1'b0, 5'b10000, 1'b0);
        vecs[2].e  = mke(1'b0, 32'd1, 1'b0, 1'b0, 32'h1F8);
        vecs[3].i  = mk(32'h200, 32'd0, 32'hFFFF_FFF8, 32'd0, 5'd0, 1'b0, 5'b10000, 1'b0);
        vecs[3].e  = mke(1'b0, 32'd0, 1'b0, 1'b0, 32'h204);
        vecs[4].i  = mk(32'h300, 32'h304, 32'd4, 32'h1003, 5'd1, 1'b1, 5'b00100, 1'b0);
        vecs[4].e  = mke(1'b1, 32'h304, 1'b0, 1'b0, 32'h1006);
        vecs[5].i  = mk(32'h400, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 5'b00010, 1'b0);
        vecs[5].e  = mke(1'b0, 32'd0, 1'b0, 1'b1, 32'h800);
        vecs[6].i  = mk(32'h800, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 5'b00001, 1'b0);
        vecs[6].e  = mke(1'b0, 32'd0, 1'b0, 1'b0, 32'h404);
        vecs[7].i  = mk(32'h1000, 32'h1004, 32'h20, 32'd0, 5'd1, 1'b1, 5'b01000, 1'b0);
        vecs[7].e  = mke(1'b1, 32'h1004, 1'b0, 1'b0, 32'h1020);
        vecs[8].i  = mk(32'h50, 32'h1234, 32'd0, 32'd0, 5'd5, 1'b1, 5'b00000, 1'b1);
        vecs[8].e  = mke(1'b1, 32'hABCD, 1'b1, 1'b0, 32'h54);
        vecs[9].i  = mk(32'hFFFF_FFFC, 32'd9, 32'd0, 32'd0, 5'd2, 1'b1, 5'b00000, 1'b0);
        vecs[9].e  = mke(1'b1, 32'd9, 1'b0, 1'b0, 32'h0);
        vecs[10].i = mk(32'h600, 32'd0, 32'h40, 32'd0, 5'd0, 1'b0, 5'b01010, 1'b0);
        vecs[10].e = mke(1'b0, 32'd0, 1'b0, 1'b1, 32'h800);
        vecs[11].i = mk(32'hFFFF_FFF0, 32'd1, 32'h20, 32'd0, 5'd0, 1'b0, 5'b10000, 1'b0);
        vecs[11].e = mke(1'b0, 32'd1, 1'b0, 1'b0, 32'h10);

        // Reset state
        #12;
        check("rst pre_ready", {31'd0, pre_ready}, 32'd1);
        check("rst npc", npc, RESET_PC);
        check("rst npc_valid", {31'd0, npc_valid}, 32'd0);
        check("rst strobes", {29'd0, rf_wen, csr_wen, trap_wen}, 32'd0);
        @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);

        for (int k = 0; k < 12; k++)
            apply($sformatf("vec%0d", k), vecs[k].i, vecs[k].e, 0);

        // Fetch stalls for 4 cycles
        apply("stall", vecs[0].i, vecs[0].e, 4);

        // Randomized instructions against the reference model
        for (int k = 0; k < 150; k++) begin
            r.res = $urandom; r.pc = $urandom; r.imm = $urandom; r.rs1 = $urandom;
            r.rd = 5'($urandom_range(0, 3)); r.rd_wen = 1'($urandom);
            sel = $urandom_range(0, 7);
            {r.brch, r.jal, r.jalr, r.ecall, r.mret} = 5'd0;
            case (sel)
                0: r.brch = 1'b1;
                1: r.jal = 1'b1;
                2: r.jalr = 1'b1;
                3: r.ecall = 1'b1;
                4: r.mret = 1'b1;
                5: ;
                default: {r.brch, r.jal, r.jalr, r.ecall, r.mret} = 5'($urandom);
            endcase
            r.csr_wen = 1'($urandom); r.csr_addr = 12'($urandom); r.csr_rdata = $urandom;
            r.mtvec = $urandom; r.mepc = $urandom;
            apply($sformatf("rnd%0d", k), r, model(r), $urandom_range(0, 2));
        end

        // Reset asserted while waiting in NPC
        @(negedge clock);
        drive(vecs[0].i);
        pre_valid = 1'b1;
        ifu_ready = 1'b0;
        @(posedge clock);
        #1;
        pre_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("npcrst valid_before", {31'd0, npc_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("npcrst npc", npc, RESET_PC);
        check("npcrst valid", {31'd0, npc_valid}, 32'd0);
        check("npcrst ready", {31'd0, pre_ready}, 32'd1);
        @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);
        check("npcrst idle_ready", {31'd0, pre_ready}, 32'd1);
        check("npcrst strobes", {29'd0, rf_wen, csr_wen, trap_wen}, 32'd0);

        // Reset asserted during the WB cycle drops the strobes
        drive(vecs[8].i);
        pre_valid = 1'b1;
        @(posedge clock);
        #1;
        pre_valid = 1'b0;
        check("wbrst strobes_before", {29'd0, rf_wen, csr_wen, trap_wen}, 32'd6);
        rst_n = 1'b0;
        #1;
        check("wbrst strobes", {29'd0, rf_wen, csr_wen, trap_wen}, 32'd0);
        check("wbrst npc", npc, RESET_PC);
        @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);
        check("wbrst nvalid", {31'd0, npc_valid}, 32'd0);
        apply("post_rst", vecs[5].i, vecs[5].e, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
